// File: rtl/uart_rx_dev.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM with
// break detection, and a first-word-fall-through receive FIFO with overrun flag.
module uart_rx_dev #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       overrun,
    output logic       frame_err
);

    localparam int TW          = $clog2(CLKS_PER_BIT);
    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int SYNC_STAGES = 2;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Line synchronizer; flops reset high so reset never looks like a start bit
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          state_reg,   state_next;
    logic [TW-1:0]   timer_reg,   timer_next;
    logic [2:0]      bit_idx_reg, bit_idx_next;
    logic [7:0]      shift_reg,   shift_next;
    logic            frame_err_reg, frame_err_next;
    logic            overrun_reg,   overrun_next;
    logic            push_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        push_req       = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    timer_next = '0;
                end
            end

            // Re-check the line half a bit in; a short glitch returns silently
            START: begin
                if (timer_reg == HALF_LAST) begin
                    timer_next   = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            DATA: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next             = '0;
                    shift_next[bit_idx_reg] = rx_s;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            STOP: begin
                if (timer_reg == BIT_LAST) begin
                    timer_next = '0;
                    if (rx_s) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = BREAK;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end

            // Wait out a held-low line so it reports only one framing error
            BREAK: begin
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // First-word-fall-through receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == FULL_CNT);
    assign pop        = !fifo_empty && rx_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle
    assign push_ok    = push_req && (!fifo_full || pop);

    always_comb begin
        overrun_next = push_req && fifo_full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage is left uninitialised; the empty flag masks stale entries
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    assign rx_valid  = !fifo_empty;
    assign rx_data   = fifo_empty ? 8'h00 : mem[rd_ptr_reg];
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_dev.sv
// Directed bench for uart_rx_dev: stimulus queues expected bytes, a monitor
// pops and compares on every accepted rx_valid/rx_ready handshake.
module tb_uart_rx_dev;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_i = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       overrun;
    logic       frame_err;

    uart_rx_dev #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_i     (rx_i),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pop_cnt = 0;
    int last_pop_cyc = 0;
    logic [7:0] sb[$];
    logic [7:0] mon_exp;

    int start_c, p0, f0, o0, n;
    logic [7:0] msg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count error pulses and score every accepted byte
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && rx_ready) begin
                pop_cnt++;
                last_pop_cyc = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: actual=0x%0h required=none", rx_data);
                end else begin
                    mon_exp = sb.pop_front();
                    check("pop_data", {24'h0, rx_data}, {24'h0, mon_exp});
                    $display("pop 0x%02h at cycle %0d", rx_data, cyc);
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame driver; optional one-cycle rx_ready pulse aligned with the stop sample
    task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit pop_at_stop);
        $display("send 0x%02h stop=%0d", d, stop_bit);
        rx_i = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = d[i];
            step(CPB);
        end
        rx_i = stop_bit;
        if (pop_at_stop) begin
            step(10);
            rx_ready = 1'b1;
            step(1);
            rx_ready = 1'b0;
            step(CPB - 11);
        end else begin
            step(CPB);
        end
    endtask

    task automatic drain_len(input string name, input int exp_len);
        int cnt;
        cnt = 0;
        rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_valid) cnt++;
        end
        check(name, cnt, exp_len);
        step(1);
    endtask

    initial begin
        // Reset state
        step(3);
        check("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_rx_data", {24'h0, rx_data}, 32'h0);
        check("reset_overrun", {31'h0, overrun}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b0;
        step(5);

        // Single byte, consumer always ready; pop seen 155 cycles after start bit
        rx_ready = 1'b1;
        start_c = cyc;
        p0 = pop_cnt;
        sb.push_back(8'hA5);
        send_byte(8'hA5, 1'b1, 1'b0);
        step(20);
        check("a5_latency", last_pop_cyc - start_c, 155);
        check("a5_pops", pop_cnt - p0, 1);
        check("a5_no_frame_err", fe_cnt, 0);
        check("a5_no_overrun", ov_cnt, 0);

        // Short glitch on the idle line
        p0 = pop_cnt;
        rx_i = 1'b0;
        step(3);
        rx_i = 1'b1;
        step(40);
        check("glitch_pops", pop_cnt - p0, 0);
        check("glitch_frame_err", fe_cnt, 0);
        sb.push_back(8'h5A);
        send_byte(8'h5A, 1'b1, 1'b0);
        step(20);
        check("after_glitch_pops", pop_cnt - p0, 1);

        // Framing error followed by a long break
        f0 = fe_cnt;
        p0 = pop_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        step(40 * CPB);
        rx_i = 1'b1;
        step(2 * CPB);
        check("break_frame_err", fe_cnt - f0, 1);
        check("break_pops", pop_cnt - p0, 0);
        sb.push_back(8'h11);
        send_byte(8'h11, 1'b1, 1'b0);
        step(20);
        check("after_break_pops", pop_cnt - p0, 1);
        check("after_break_frame_err", fe_cnt - f0, 1);

        // Overrun: five bytes into a four-entry buffer
        rx_ready = 1'b0;
        o0 = ov_cnt;
        for (int b = 1; b <= 5; b++) begin
            msg = 8'(b);
            if (b <= DEPTH) sb.push_back(msg);
            send_byte(msg, 1'b1, 1'b0);
        end
        step(20);
        check("overrun_pulses", ov_cnt - o0, 1);
        check("full_rx_valid", {31'h0, rx_valid}, 32'h1);
        check("full_head", {24'h0, rx_data}, 32'h01);
        drain_len("overrun_drain_len", 4);
        check("overrun_sb_empty", sb.size(), 0);

        // Push into a full buffer coinciding with a pop
        rx_ready = 1'b0;
        o0 = ov_cnt;
        for (int b = 8'h21; b <= 8'h24; b++) begin
            msg = 8'(b);
            sb.push_back(msg);
            send_byte(msg, 1'b1, 1'b0);
        end
        sb.push_back(8'h25);
        send_byte(8'h25, 1'b1, 1'b1);
        step(20);
        check("coincide_overrun", ov_cnt - o0, 0);
        check("coincide_head", {24'h0, rx_data}, 32'h22);
        drain_len("coincide_drain_len", 4);
        check("coincide_sb_empty", sb.size(), 0);

        // Reset in the middle of a frame
        rx_ready = 1'b0;
        sb.push_back(8'h99);
        send_byte(8'h99, 1'b1, 1'b0);
        step(20);
        check("pre_reset_valid", {31'h0, rx_valid}, 32'h1);
        check("pre_reset_data", {24'h0, rx_data}, 32'h99);
        msg = 8'h7E;
        rx_i = 1'b0;
        step(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_i = msg[i];
            step(CPB);
        end
        rx_i = msg[4];
        step(CPB / 2);
        #2 rst = 1'b1;
        #1;
        check("midreset_rx_valid", {31'h0, rx_valid}, 32'h0);
        check("midreset_rx_data", {24'h0, rx_data}, 32'h0);
        check("midreset_overrun", {31'h0, overrun}, 32'h0);
        check("midreset_frame_err", {31'h0, frame_err}, 32'h0);
        sb.delete();
        step(3);
        rx_i = 1'b1;
        rst = 1'b0;
        step(2 * CPB);
        rx_ready = 1'b1;
        p0 = pop_cnt;
        f0 = fe_cnt;
        sb.push_back(8'h7E);
        send_byte(8'h7E, 1'b1, 1'b0);
        step(20);
        check("post_reset_pops", pop_cnt - p0, 1);
        check("post_reset_frame_err", fe_cnt - f0, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_dev.md
UART_RX_DEV -- requirements
Module: uart_rx_dev

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, meaning clk cycles per serial bit (legal range 4 or more).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning receive-buffer entries (power of 2, 2 or more).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port rx_i, input, 1 bit: asynchronous serial line, 8N1 format, LSB first, idle high.
REQ-006 SHALL have port rx_valid, output, 1 bit: a received byte is available.
REQ-007 SHALL have port rx_ready, input, 1 bit: the consumer accepts the byte on rx_data.
REQ-008 SHALL have port rx_data, output, 8 bits: oldest buffered byte; valid only while rx_valid is 1.
REQ-009 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples 0.

Function
REQ-011 SHALL pass rx_i through a 2-flop synchronizer; both flops reset to 1; all line decisions use the synchronized value (rx_s).
REQ-012 SHALL implement the FSM states IDLE, START, DATA, STOP and BREAK with a bit-timer counter and a 3-bit bit index.
REQ-013 In IDLE, rx_s = 0 SHALL move the FSM to START and clear the timer.
REQ-014 In START, after CLKS_PER_BIT/2 cycles (integer division), the FSM SHALL go to DATA if rx_s = 0, else to IDLE (glitch rejection, nothing reported).
REQ-015 In DATA, every CLKS_PER_BIT cycles the FSM SHALL shift rx_s into bit [index] LSB first; after bit 7 it SHALL go to STOP.
REQ-016 In STOP, after CLKS_PER_BIT cycles, if rx_s = 1 the byte SHALL be pushed and the FSM SHALL go to IDLE.
REQ-017 In STOP, if rx_s = 0 at the stop sample, the byte SHALL be discarded, frame_err SHALL pulse for 1 cycle and the FSM SHALL go to BREAK.
REQ-018 In BREAK, the FSM SHALL remain until rx_s = 1 and then go to IDLE, so a held-low line produces exactly one frame_err.
REQ-019 The buffer SHALL be a first-word-fall-through FIFO: rx_valid = not empty; rx_data = head entry, stable while rx_valid = 1 and no pop occurs.
REQ-020 A pop SHALL occur in a cycle where rx_valid = 1 and rx_ready = 1; rx_ready while empty SHALL have no effect.
REQ-021 A pushed byte SHALL appear on rx_valid/rx_data in the cycle after the stop-sample cycle when the FIFO was empty.
REQ-022 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle; the occupancy count is then unchanged.
REQ-023 A push into a full FIFO with no pop SHALL drop the new byte, keep the existing contents and pulse overrun for 1 cycle.
REQ-024 Simultaneous push and pop on an empty FIFO are impossible, because pop requires rx_valid; the push proceeds normally.
REQ-025 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-026 rst asserted SHALL immediately force the FSM to IDLE, clear the timer, bit index, pointers and count, and set the synchronizer flops to 1.
REQ-027 During reset, outputs SHALL be rx_valid = 0, rx_data = 0, overrun = 0 and frame_err = 0; FIFO storage contents need not be cleared.
REQ-028 A reset asserted in the middle of a frame SHALL abort the frame; after release, reception SHALL resume at the next falling edge while in IDLE.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-029 Send 0xA5 with rx_ready = 1 -> rx_valid high for 1 cycle with rx_data = 0xA5, one cycle after the stop sample; no error pulses.
REQ-030 Send a 3-cycle low glitch on an idle line -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-031 Send 0x3C with the stop bit forced 0, then hold the line low for 40 bit times -> exactly one frame_err pulse and no byte; then send 0x11 -> 0x11 received.
REQ-032 With rx_ready = 0, send 0x01..0x05 -> 4 bytes buffered and one overrun pulse on 0x05; then raise rx_ready -> 0x01, 0x02, 0x03, 0x04 popped in order, one per cycle.
REQ-033 With the FIFO full, send a byte timed so that its push coincides with a pop -> the byte is accepted, no overrun, count stays 4.
REQ-034 Assert rst during bit 4 of a frame -> outputs zero immediately; after release, the next full frame 0x7E is received correctly.
